// File: rtl/aes_spi_master_if.sv
// Host-side SPI master link: request/frame handshake plus the four SPI wires.
// The master modport is the SPI engine; the slave modport is the host logic that drives it.
interface aes_spi_master_if #(
    parameter int FRAME_W = 392
);
    logic               start;
    logic [FRAME_W-1:0] tx_frame;
    logic               ready;
    logic               busy;
    logic               done;
    logic [FRAME_W-1:0] rx_frame;
    logic               sclk;
    logic               cs;
    logic               mosi;
    logic               miso;

    modport master (
        input  start, tx_frame, miso,
        output ready, busy, done, rx_frame, sclk, cs, mosi
    );

    modport slave (
        output start, tx_frame, miso,
        input  ready, busy, done, rx_frame, sclk, cs, mosi
    );
endinterface

// File: rtl/aes_spi_master.sv
// Mode-0, MSB-first SPI master that exchanges one FRAME_W-bit frame per cs-low window,
// full duplex, with registered outputs and a fixed cs-high gap between frames.
module aes_spi_master #(
    parameter int FRAME_W  = 392,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    aes_spi_master_if.master  bus
);
    localparam int CNT_W = 16;
    localparam int BIT_W = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [FRAME_W-1:0] tx_sh_reg;
    logic [FRAME_W-1:0] rx_sh_reg;
    logic [FRAME_W-1:0] rx_frame_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               sclk_reg;
    logic               cs_reg;
    logic               mosi_reg;

    assign bus.ready    = ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.rx_frame = rx_frame_reg;
    assign bus.sclk     = sclk_reg;
    assign bus.cs       = cs_reg;
    assign bus.mosi     = mosi_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_frame_reg <= '0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            cs_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        tx_sh_reg   <= bus.tx_frame;
                        rx_sh_reg   <= '0;
                        bit_cnt_reg <= BIT_W'(FRAME_W);
                        cnt_reg     <= '0;
                        cs_reg      <= 1'b0;
                        sclk_reg    <= 1'b0;
                        mosi_reg    <= bus.tx_frame[FRAME_W-1];
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg   <= '0;
                        sclk_reg  <= 1'b1;
                        state_reg <= S_HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg     <= '0;
                        sclk_reg    <= 1'b0;
                        rx_sh_reg   <= {rx_sh_reg[FRAME_W-2:0], bus.miso};
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        if (bit_cnt_reg == BIT_W'(1)) begin
                            // Last bit sampled: go straight to hold, no trailing low phase.
                            state_reg <= S_HOLD;
                        end else begin
                            // Falling edge: present the next bit together with sclk going low.
                            tx_sh_reg <= tx_sh_reg << 1;
                            mosi_reg  <= tx_sh_reg[FRAME_W-2];
                            state_reg <= S_LOW;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg   <= '0;
                        sclk_reg  <= 1'b1;
                        state_reg <= S_HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_reg      <= '0;
                        cs_reg       <= 1'b1;
                        mosi_reg     <= 1'b0;
                        rx_frame_reg <= rx_sh_reg;
                        done_reg     <= 1'b1;
                        state_reg    <= S_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    // The done cycle is the first of the CLK_DIV gap cycles.
                    if (cnt_reg == DIV_LAST) begin
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    cs_reg    <= 1'b1;
                    sclk_reg  <= 1'b0;
                    mosi_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench: small 16-bit master with loopback/tied miso, plus a default-size instance.
module tb_aes_spi_master;
    localparam int W  = 16;
    localparam int WD = 392;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_spi_master_if #(.FRAME_W(W))  bus  ();
    aes_spi_master_if #(.FRAME_W(WD)) bus2 ();

    aes_spi_master #(.FRAME_W(W), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );
    aes_spi_master dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master)
    );

    // miso source: 0 = loopback, 1 = tied high, 2 = tied low
    int miso_mode;
    assign bus.miso  = (miso_mode == 0) ? bus.mosi : (miso_mode == 1);
    assign bus2.miso = bus2.mosi;

    // Cumulative monitors sampled on the falling clock edge.
    int          rises, cs_low, done_cnt, high_run, last_gap, viol, cs2_low, done2_cnt;
    logic        prev_sclk, prev_mosi, prev_cs;
    logic [W-1:0] mosi_hist;

    initial begin
        rises = 0; cs_low = 0; done_cnt = 0; high_run = 0; last_gap = 0; viol = 0;
        cs2_low = 0; done2_cnt = 0; prev_sclk = 0; prev_mosi = 0; prev_cs = 1; mosi_hist = '0;
    end

    always @(negedge clk) begin
        if (bus.sclk && !prev_sclk) begin
            rises     <= rises + 1;
            mosi_hist <= {mosi_hist[W-2:0], bus.mosi};
        end
        if (bus.sclk && prev_sclk && (bus.mosi !== prev_mosi)) viol <= viol + 1;
        if (!bus.cs) begin
            cs_low   <= cs_low + 1;
            high_run <= 0;
            if (prev_cs) last_gap <= high_run;
        end else begin
            high_run <= high_run + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (!bus2.cs) cs2_low <= cs2_low + 1;
        if (bus2.done) done2_cnt <= done2_cnt + 1;
        prev_sclk <= bus.sclk;
        prev_mosi <= bus.mosi;
        prev_cs   <= bus.cs;
    end

    task automatic check(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [W-1:0] tx);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.tx_frame = tx;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check({tag, "_done_seen"}, WD'(seen), WD'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int r0, c0, d0;
    logic [WD-1:0] big;

    initial begin
        checks = 0; errors = 0; miso_mode = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.tx_frame = '0;
        bus2.start = 1'b0; bus2.tx_frame = '0;
        idle(3);
        check("rst_cs",    WD'(bus.cs),       WD'(1));
        check("rst_sclk",  WD'(bus.sclk),     WD'(0));
        check("rst_mosi",  WD'(bus.mosi),     WD'(0));
        check("rst_ready", WD'(bus.ready),    WD'(1));
        check("rst_busy",  WD'(bus.busy),     WD'(0));
        check("rst_done",  WD'(bus.done),     WD'(0));
        check("rst_rx",    WD'(bus.rx_frame), WD'(0));
        reset = 1'b0;
        idle(2);

        // 1: loopback A5C3
        r0 = rises; c0 = cs_low; d0 = done_cnt;
        start_frame(16'hA5C3);
        wait_done("t1", 200);
        check("t1_done_cs",   WD'(bus.cs),   WD'(1));
        check("t1_done_mosi", WD'(bus.mosi), WD'(0));
        idle(10);
        check("t1_rx",     WD'(bus.rx_frame), WD'(16'hA5C3));
        check("t1_dones",  WD'(done_cnt - d0), WD'(1));
        check("t1_rises",  WD'(rises - r0),    WD'(16));
        check("t1_cs_low", WD'(cs_low - c0),   WD'(66));
        $display("t1 loopback tx=a5c3 rx=%h", bus.rx_frame);

        // 2: miso tied high, then low
        miso_mode = 1;
        start_frame(16'h8001);
        wait_done("t2a", 200);
        check("t2a_rx",   WD'(bus.rx_frame), WD'(16'hFFFF));
        check("t2a_mosi", WD'(mosi_hist),    WD'(16'h8001));
        $display("t2 miso=1 tx=8001 rx=%h mosi=%h", bus.rx_frame, mosi_hist);
        miso_mode = 2;
        idle(5);
        start_frame(16'h8001);
        wait_done("t2b", 200);
        check("t2b_rx",   WD'(bus.rx_frame), WD'(16'h0000));
        check("t2b_mosi", WD'(mosi_hist),    WD'(16'h8001));
        $display("t2 miso=0 tx=8001 rx=%h mosi=%h", bus.rx_frame, mosi_hist);
        miso_mode = 0;
        idle(5);

        // 3: start mid-frame ignored, tx_frame change after accept has no effect
        d0 = done_cnt;
        start_frame(16'hABCD);
        idle(10);
        start_frame(16'h1234);
        wait_done("t3", 200);
        idle(1);
        c0 = cs_low;
        idle(30);
        check("t3_rx",     WD'(bus.rx_frame), WD'(16'hABCD));
        check("t3_dones",  WD'(done_cnt - d0), WD'(1));
        check("t3_no_2nd", WD'(cs_low - c0),   WD'(0));
        check("t3_ready",  WD'(bus.ready),     WD'(1));
        $display("t3 mid-frame start ignored rx=%h", bus.rx_frame);

        // 4: reset after the 5th sclk rise
        r0 = rises; d0 = done_cnt;
        start_frame(16'hF0F0);
        for (int i = 0; i < 200 && (rises - r0) < 5; i++) @(negedge clk);
        check("t4_reach5", WD'(rises - r0), WD'(5));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_cs",    WD'(bus.cs),       WD'(1));
        check("t4_sclk",  WD'(bus.sclk),     WD'(0));
        check("t4_mosi",  WD'(bus.mosi),     WD'(0));
        check("t4_ready", WD'(bus.ready),    WD'(1));
        check("t4_rx",    WD'(bus.rx_frame), WD'(0));
        idle(80);
        check("t4_nodone", WD'(done_cnt - d0), WD'(0));
        start_frame(16'h00FF);
        wait_done("t4b", 200);
        check("t4_rx2", WD'(bus.rx_frame), WD'(16'h00FF));
        $display("t4 reset mid-frame, then rx=%h", bus.rx_frame);
        idle(5);

        // 5: start held high across two frames
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.tx_frame = 16'h3C5A;
        wait_done("t5a", 200);
        check("t5_rx1", WD'(bus.rx_frame), WD'(16'h3C5A));
        bus.tx_frame = 16'h5AA5;
        for (int i = 0; i < 20 && !bus.ready; i++) @(negedge clk);
        @(negedge clk);
        check("t5_accept2", WD'(bus.busy), WD'(1));
        bus.start = 1'b0;
        wait_done("t5b", 200);
        idle(30);
        check("t5_rx2",  WD'(bus.rx_frame),  WD'(16'h5AA5));
        check("t5_gap",  WD'(last_gap),      WD'(3));
        check("t5_dones", WD'(done_cnt - d0), WD'(2));
        check("mosi_stable_high", WD'(viol), WD'(0));
        $display("t5 back-to-back rx=%h gap=%0d", bus.rx_frame, last_gap);

        // 6: default-size instance, loopback of a pseudo-random 392-bit frame
        for (int i = 0; i < WD; i++) big[i] = 1'($urandom_range(0, 1));
        c0 = cs2_low; d0 = done2_cnt;
        @(negedge clk);
        bus2.start = 1'b1; bus2.tx_frame = big;
        @(negedge clk);
        bus2.start = 1'b0; bus2.tx_frame = '0;
        for (int i = 0; i < 5000 && !bus2.done; i++) @(negedge clk);
        check("t6_done", WD'(bus2.done), WD'(1));
        idle(20);
        check("t6_rx",     bus2.rx_frame,        big);
        check("t6_cs_low", WD'(cs2_low - c0),    WD'(3136));
        check("t6_dones",  WD'(done2_cnt - d0),  WD'(1));
        $display("t6 default frame cs_low=%0d", cs2_low - c0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
